mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter CNT_WIDTH, default 16: width of the per-port completed-transaction counters.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 i_read  in  1  instruction-port read request, held until i_resp.
REQ-005 i_addr  in  32  instruction-port byte address.
REQ-006 i_rdata  out  32  instruction-port read data, valid only while i_resp=1.
REQ-007 i_resp  out  1  instruction-port completion pulse.
REQ-008 d_read / d_write  in  1 each  data-port requests, held until d_resp.
REQ-009 d_addr  in  32  data-port byte address.
REQ-010 d_wmask  in  4  data-port byte-write enables.
REQ-011 d_wdata  in  32  data-port write data.
REQ-012 d_rdata  out  32  data-port read data, valid only while d_resp=1.
REQ-013 d_resp  out  1  data-port completion pulse.
REQ-014 m_read / m_write  out  1 each  shared-memory requests.
REQ-015 m_addr  out  32, m_wmask  out  4, m_wdata  out  32  shared-memory request fields.
REQ-016 m_rdata  in  32, m_resp  in  1  shared-memory response.
REQ-017 error  out  1  sticky protocol-violation flag.
REQ-018 i_count / d_count  out  CNT_WIDTH  completed transactions per port, saturating.

Function
REQ-019 FSM states SHALL be IDLE, SERVE_I, SERVE_D; exactly one active.
REQ-020 In IDLE, m_read=m_write=0; m_addr/m_wmask/m_wdata SHALL be 0.
REQ-021 IDLE, only i_read -> SERVE_I next cycle; only d_read|d_write -> SERVE_D next cycle.
REQ-022 IDLE with both ports requesting: grant the port not recorded in last_grant; last_grant updates on every grant.
REQ-023 In SERVE_I: m_read=1, m_write=0, m_addr=i_addr, m_wmask=0, m_wdata=0, combinationally from current inputs.
REQ-024 In SERVE_D: m_read=d_read, m_write=d_write, m_addr=d_addr, m_wmask=d_wmask, m_wdata=d_wdata.
REQ-025 Granted port's resp SHALL equal m_resp in the same cycle; its rdata SHALL equal m_rdata; other port's resp=0.
REQ-026 i_rdata/d_rdata SHALL be 0 whenever the corresponding resp=0.
REQ-027 On m_resp=1 in SERVE_x: return to IDLE next cycle; no back-to-back grant from SERVE state (minimum one IDLE cycle between transactions).
REQ-028 Latency: request asserted in IDLE at cycle t -> m_read/m_write at t+1; resp at the cycle m_resp arrives.
REQ-029 m_resp=1 while in IDLE SHALL be ignored (no upstream resp, no counter change).
REQ-030 Requester drops its request before resp while granted: FSM stays in SERVE_x and drives deasserted request; error set.
REQ-031 d_read=d_write=1 in any cycle: error set; in IDLE the data port is not granted that cycle.
REQ-032 error SHALL remain 1 until reset.
REQ-033 i_count/d_count SHALL increment by 1 per completed transaction of that port, saturating at all-ones.

Reset
REQ-034 rst=1 SHALL immediately force: state IDLE, last_grant=D (instruction wins first tie), error=0, counters=0, all m_* outputs 0, i_resp=d_resp=0.
REQ-035 Reset mid-transaction SHALL abandon it; a subsequent stale m_resp in IDLE is ignored per REQ-029.

Verification
REQ-036 Single I read: i_read=1, i_addr=0x60000000, m_resp one cycle after m_read with m_rdata=0x00000013 -> m_read at t+1, i_resp=1 with i_rdata=0x00000013, i_count=1, IDLE next.
REQ-037 Simultaneous requests after reset: i_read and d_read both held -> I served first, one IDLE cycle, then D; third contention grants I again.
REQ-038 D write: d_write=1, d_addr=0x60000100, d_wmask=0xC, d_wdata=0xDEADBEEF -> m_write=1 with identical fields, d_resp on m_resp, d_count=1, i_resp never asserted.
REQ-039 Protocol error: d_read=d_write=1 for one cycle -> error=1, held through subsequent legal traffic until rst.
REQ-040 Reset during SERVE_D with m_resp arriving after rst deasserts -> no d_resp, d_count=0, m_* outputs 0.
REQ-041 Saturation: with CNT_WIDTH=2, five I reads -> i_count reads 1,2,3,3,3.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (instruction / data) arbiter onto a single shared memory port.
// Alternating priority on contention, sticky protocol-error flag, saturating per-port counters.
module mem_arbiter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_read,
    input  logic [31:0]          i_addr,
    output logic [31:0]          i_rdata,
    output logic                 i_resp,
    input  logic                 d_read,
    input  logic                 d_write,
    input  logic [31:0]          d_addr,
    input  logic [3:0]           d_wmask,
    input  logic [31:0]          d_wdata,
    output logic [31:0]          d_rdata,
    output logic                 d_resp,
    output logic                 m_read,
    output logic                 m_write,
    output logic [31:0]          m_addr,
    output logic [3:0]           m_wmask,
    output logic [31:0]          m_wdata,
    input  logic [31:0]          m_rdata,
    input  logic                 m_resp,
    output logic                 error,
    output logic [CNT_WIDTH-1:0] i_count,
    output logic [CNT_WIDTH-1:0] d_count
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

    state_t state, state_nxt;
    logic   last_grant_d, last_grant_d_nxt;
    logic   d_conflict, d_req, err_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last_grant_d <= 1'b1;
            error        <= 1'b0;
            i_count      <= '0;
            d_count      <= '0;
        end else begin
            state        <= state_nxt;
            last_grant_d <= last_grant_d_nxt;
            if (err_set)
                error <= 1'b1;
            if (i_resp && i_count != '1)
                i_count <= i_count + CNT_WIDTH'(1);
            if (d_resp && d_count != '1)
                d_count <= d_count + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        d_conflict       = d_read & d_write;
        d_req            = (d_read | d_write) & ~d_conflict;
        state_nxt        = state;
        last_grant_d_nxt = last_grant_d;
        err_set          = d_conflict;
        m_read           = 1'b0;
        m_write          = 1'b0;
        m_addr           = '0;
        m_wmask          = '0;
        m_wdata          = '0;
        i_resp           = 1'b0;
        i_rdata          = '0;
        d_resp           = 1'b0;
        d_rdata          = '0;

        case (state)
            IDLE: begin
                // On a tie the port that did not win last time gets the grant.
                if (i_read && (!d_req || last_grant_d)) begin
                    state_nxt        = SERVE_I;
                    last_grant_d_nxt = 1'b0;
                end else if (d_req) begin
                    state_nxt        = SERVE_D;
                    last_grant_d_nxt = 1'b1;
                end
            end
            SERVE_I: begin
                m_read  = 1'b1;
                m_addr  = i_addr;
                i_resp  = m_resp;
                i_rdata = m_resp ? m_rdata : '0;
                if (!i_read)
                    err_set = 1'b1;
                if (m_resp)
                    state_nxt = IDLE;
            end
            SERVE_D: begin
                m_read  = d_read;
                m_write = d_write;
                m_addr  = d_addr;
                m_wmask = d_wmask;
                m_wdata = d_wdata;
                d_resp  = m_resp;
                d_rdata = m_resp ? m_rdata : '0;
                if (!(d_read || d_write))
                    err_set = 1'b1;
                if (m_resp)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized legal traffic with sporadic resets.
module tb_mem_arbiter;

    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_read = 1'b0;
    logic [31:0]   i_addr = '0;
    logic [31:0]   i_rdata;
    logic          i_resp;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [31:0]   d_addr = '0;
    logic [3:0]    d_wmask = '0;
    logic [31:0]   d_wdata = '0;
    logic [31:0]   d_rdata;
    logic          d_resp;
    logic          m_read;
    logic          m_write;
    logic [31:0]   m_addr;
    logic [3:0]    m_wmask;
    logic [31:0]   m_wdata;
    logic [31:0]   m_rdata = '0;
    logic          m_resp = 1'b0;
    logic          error;
    logic [CW-1:0] i_count;
    logic [CW-1:0] d_count;

    int n_cmp = 0;
    int n_bad = 0;

    mem_arbiter #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wmask(d_wmask),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
        .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wmask(m_wmask),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_resp(m_resp),
        .error(error), .i_count(i_count), .d_count(d_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the memory (0 none, 1 I, 2 D), who won last, error, counts.
    int owner = 0;
    bit last_d = 1'b1;
    bit err_m = 1'b0;
    int icnt = 0;
    int dcnt = 0;

    always @(negedge clk) begin
        logic [31:0] e_ma, e_wd, e_ird, e_drd;
        logic [3:0]  e_wm;
        logic        e_mr, e_mw, e_ir, e_dr, ie, de;
        if (rst) begin
            owner = 0; last_d = 1'b1; err_m = 1'b0; icnt = 0; dcnt = 0;
        end
        e_mr = 0; e_mw = 0; e_ma = 0; e_wm = 0; e_wd = 0;
        e_ir = 0; e_ird = 0; e_dr = 0; e_drd = 0;
        if (!rst && owner == 1) begin
            e_mr = 1; e_ma = i_addr; e_ir = m_resp; e_ird = m_resp ? m_rdata : 32'h0;
        end else if (!rst && owner == 2) begin
            e_mr = d_read; e_mw = d_write; e_ma = d_addr; e_wm = d_wmask; e_wd = d_wdata;
            e_dr = m_resp; e_drd = m_resp ? m_rdata : 32'h0;
        end
        chk("m_read", 32'(m_read), 32'(e_mr));
        chk("m_write", 32'(m_write), 32'(e_mw));
        chk("m_addr", m_addr, e_ma);
        chk("m_wmask", 32'(m_wmask), 32'(e_wm));
        chk("m_wdata", m_wdata, e_wd);
        chk("i_resp", 32'(i_resp), 32'(e_ir));
        chk("i_rdata", i_rdata, e_ird);
        chk("d_resp", 32'(d_resp), 32'(e_dr));
        chk("d_rdata", d_rdata, e_drd);
        chk("error", 32'(error), 32'(err_m));
        chk("i_count", 32'(i_count), 32'(icnt));
        chk("d_count", 32'(d_count), 32'(dcnt));
        if (!rst) begin
            if (d_read && d_write) err_m = 1'b1;
            if (owner == 1) begin
                if (!i_read) err_m = 1'b1;
                if (m_resp) begin owner = 0; if (icnt < CMAX) icnt++; end
            end else if (owner == 2) begin
                if (!(d_read || d_write)) err_m = 1'b1;
                if (m_resp) begin owner = 0; if (dcnt < CMAX) dcnt++; end
            end else begin
                ie = i_read;
                de = d_read ^ d_write;
                if (ie && de) owner = last_d ? 1 : 2;
                else if (ie) owner = 1;
                else if (de) owner = 2;
                if (owner != 0) last_d = (owner == 2);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        step(); rst = 1'b1;
        step(); rst = 1'b0;
    endtask

    task automatic i_txn(input logic [31:0] data, input int exp_cnt);
        step(); i_read = 1'b1; i_addr = 32'h6000_0000;
        @(negedge clk); chk("lat_idle_mread", 32'(m_read), 32'h0);
        step();
        @(negedge clk); chk("lat_mread", 32'(m_read), 32'h1);
        chk("lat_maddr", m_addr, 32'h6000_0000);
        step(); m_resp = 1'b1; m_rdata = data;
        @(negedge clk); chk("lit_i_resp", 32'(i_resp), 32'h1);
        chk("lit_i_rdata", i_rdata, data);
        step(); m_resp = 1'b0; i_read = 1'b0;
        @(negedge clk); chk("lit_i_count", 32'(i_count), 32'(exp_cnt));
        chk("lit_back_idle", 32'(m_read), 32'h0);
    endtask

    initial begin
        logic idone, ddone;
        step(); step(); rst = 1'b0;
        @(negedge clk); chk("lit_rst_error", 32'(error), 32'h0);
        chk("lit_rst_icount", 32'(i_count), 32'h0);

        // single read, then saturation of a 2-bit counter
        i_txn(32'h0000_0013, 1);
        i_txn(32'h0000_0014, 2);
        i_txn(32'h0000_0015, 3);
        i_txn(32'h0000_0016, 3);
        i_txn(32'h0000_0017, 3);

        // contention: I, idle, D, idle, I
        pulse_reset();
        step(); i_read = 1'b1; i_addr = 32'h0000_1000; d_read = 1'b1; d_addr = 32'h0000_2000;
        @(negedge clk); chk("lit_tie_idle", 32'(m_read), 32'h0);
        step(); m_resp = 1'b1; m_rdata = 32'h11;
        @(negedge clk); chk("lit_tie1_addr", m_addr, 32'h0000_1000);
        chk("lit_tie1_dresp", 32'(d_resp), 32'h0);
        step(); m_resp = 1'b0;
        @(negedge clk); chk("lit_tie_gap1", 32'(m_read), 32'h0);
        step(); m_resp = 1'b1; m_rdata = 32'h22;
        @(negedge clk); chk("lit_tie2_addr", m_addr, 32'h0000_2000);
        chk("lit_tie2_drdata", d_rdata, 32'h22);
        step(); m_resp = 1'b0;
        @(negedge clk); chk("lit_tie_gap2", 32'(m_read), 32'h0);
        step(); m_resp = 1'b1;
        @(negedge clk); chk("lit_tie3_addr", m_addr, 32'h0000_1000);
        step(); m_resp = 1'b0; i_read = 1'b0; d_read = 1'b0;

        // data write
        pulse_reset();
        step(); d_write = 1'b1; d_addr = 32'h6000_0100; d_wmask = 4'hC; d_wdata = 32'hDEAD_BEEF;
        step();
        @(negedge clk); chk("lit_dw_mwrite", 32'(m_write), 32'h1);
        chk("lit_dw_wmask", 32'(m_wmask), 32'hC);
        chk("lit_dw_wdata", m_wdata, 32'hDEAD_BEEF);
        step(); m_resp = 1'b1;
        @(negedge clk); chk("lit_dw_resp", 32'(d_resp), 32'h1);
        chk("lit_dw_iresp", 32'(i_resp), 32'h0);
        step(); m_resp = 1'b0; d_write = 1'b0;
        @(negedge clk); chk("lit_dw_count", 32'(d_count), 32'h1);

        // reset while serving D, stale response afterwards
        pulse_reset();
        step(); d_read = 1'b1; d_addr = 32'h0000_0040;
        step();
        @(negedge clk); chk("lit_rd_mread", 32'(m_read), 32'h1);
        step(); rst = 1'b1;
        @(negedge clk); chk("lit_rd_rst_mread", 32'(m_read), 32'h0);
        step(); rst = 1'b0; d_read = 1'b0; m_resp = 1'b1;
        @(negedge clk); chk("lit_stale_dresp", 32'(d_resp), 32'h0);
        step(); m_resp = 1'b0;
        @(negedge clk); chk("lit_stale_dcount", 32'(d_count), 32'h0);

        // read+write conflict, then a dropped request while granted
        pulse_reset();
        step(); d_read = 1'b1; d_write = 1'b1;
        step(); d_read = 1'b0; d_write = 1'b0;
        @(negedge clk); chk("lit_conf_error", 32'(error), 32'h1);
        chk("lit_conf_nogrant", 32'(m_read | m_write), 32'h0);
        step(); i_read = 1'b1; i_addr = 32'h0000_0800;
        step(); i_read = 1'b0;
        @(negedge clk); chk("lit_drop_mread", 32'(m_read), 32'h1);
        step(); m_resp = 1'b1;
        @(negedge clk); chk("lit_err_sticky", 32'(error), 32'h1);
        step(); m_resp = 1'b0;
        pulse_reset();
        @(negedge clk); chk("lit_err_cleared", 32'(error), 32'h0);

        // randomized legal traffic
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            idone = i_resp;
            ddone = d_resp;
            step();
            rst = ($urandom_range(0, 199) == 0);
            if (idone) i_read = 1'b0;
            else if (!i_read && $urandom_range(0, 2) == 0) begin
                i_read = 1'b1;
                i_addr = $urandom;
            end
            if (ddone) begin
                d_read = 1'b0; d_write = 1'b0;
            end else if (!(d_read || d_write) && $urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 1) d_read = 1'b1;
                else d_write = 1'b1;
                d_addr  = $urandom;
                d_wmask = 4'($urandom);
                d_wdata = $urandom;
            end
            m_resp  = ($urandom_range(0, 2) == 0);
            m_rdata = $urandom;
        end
        step(); rst = 1'b0; m_resp = 1'b0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
